// File: rtl/featuremap_window_gen.sv
// featuremap_window_gen
//   Streaming 3x3 window generator for a bank of per-channel Conv2D3x3 MACs.
//   Pixels arrive in raster order, one per valid_in cycle, with all channels
//   packed side by side. Two line buffers (rows r-1 and r-2) and a column
//   shift register per channel supply the nine taps of every unpadded window
//   whose top-left corner lies on the stride grid.
//
// Ports
//   Clk        : clock, rising edge
//   Rst        : synchronous active-high reset (counters and outputs)
//   data_in    : CHANNELS*DATA_WIDTH, channel ch at [ch*DATA_WIDTH +: DATA_WIDTH]
//   valid_in   : data_in carries a pixel this cycle
//   window_out : 9*CHANNELS*DATA_WIDTH, tap k of channel ch at
//                [(ch*9+k)*DATA_WIDTH +: DATA_WIDTH], w0 top-left .. w8 bottom-right
//   valid_out  : window_out holds a new window this cycle
//   last_out   : final window of the frame (only with valid_out)
module featuremap_window_gen #(
    parameter int DATA_WIDTH = 32,
    parameter int CHANNELS   = 32,
    parameter int IMG_SIZE   = 104,
    parameter int STRIDE     = 1
) (
    input  logic                             Clk,
    input  logic                             Rst,
    input  logic [CHANNELS*DATA_WIDTH-1:0]   data_in,
    input  logic                             valid_in,
    output logic [9*CHANNELS*DATA_WIDTH-1:0] window_out,
    output logic                             valid_out,
    output logic                             last_out
);

    localparam int PIX_W = CHANNELS * DATA_WIDTH;
    localparam int WIN_W = 9 * PIX_W;
    localparam int CNT_W = $clog2(IMG_SIZE);

    // Last row/column index that lies on the stride grid (same for both axes).
    localparam int LAST_INT = (STRIDE == 1) ? IMG_SIZE - 1 :
                              ((((IMG_SIZE - 1) % 2) == 0) ? IMG_SIZE - 1 : IMG_SIZE - 2);
    localparam logic [CNT_W-1:0] MAX_IDX  = CNT_W'(IMG_SIZE - 1);
    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(LAST_INT);

    generate
        if (STRIDE != 1 && STRIDE != 2) begin : g_bad_stride
            $error("featuremap_window_gen: STRIDE must be 1 or 2");
        end
        if (IMG_SIZE < 3) begin : g_bad_size
            $error("featuremap_window_gen: IMG_SIZE must be >= 3");
        end
    endgenerate

    // True when a row/column index can be the bottom/right edge of an emitted window.
    function automatic logic on_grid(input logic [CNT_W-1:0] idx);
        logic ok;
        ok = (idx >= CNT_W'(2));
        if (STRIDE == 2) begin
            // (idx-2) mod 2 == 0 is the same as idx being even
            ok = ok && !idx[0];
        end
        return ok;
    endfunction

    logic [CNT_W-1:0] col, row;
    logic [PIX_W-1:0] line_a [IMG_SIZE];
    logic [PIX_W-1:0] line_b [IMG_SIZE];

    // Middle and right tap columns; the left column of the next window is the
    // current middle column, so it never needs its own register.
    logic [PIX_W-1:0] top_mid_p0, top_rgt_p0;
    logic [PIX_W-1:0] mid_mid_p0, mid_rgt_p0;
    logic [PIX_W-1:0] bot_mid_p0, bot_rgt_p0;

    logic [PIX_W-1:0] a_rd, b_rd;
    logic [WIN_W-1:0] win_next;
    logic             accept, emit, emit_last;
    logic             vld_p1;

    // Reset wins over a simultaneous pixel: the pixel is dropped entirely.
    assign accept    = valid_in && !Rst;
    assign a_rd      = line_a[col];
    assign b_rd      = line_b[col];
    assign emit      = accept && on_grid(row) && on_grid(col);
    assign emit_last = emit && (row == LAST_IDX) && (col == LAST_IDX);

    // Window as it stands after this pixel shifts in: old mid -> left,
    // old right -> mid, {B[col], A[col], data_in} -> right.
    always_comb begin
        win_next = '0;
        for (int ch = 0; ch < CHANNELS; ch++) begin
            win_next[(ch*9+0)*DATA_WIDTH +: DATA_WIDTH] = top_mid_p0[ch*DATA_WIDTH +: DATA_WIDTH];
            win_next[(ch*9+1)*DATA_WIDTH +: DATA_WIDTH] = top_rgt_p0[ch*DATA_WIDTH +: DATA_WIDTH];
            win_next[(ch*9+2)*DATA_WIDTH +: DATA_WIDTH] = b_rd[ch*DATA_WIDTH +: DATA_WIDTH];
            win_next[(ch*9+3)*DATA_WIDTH +: DATA_WIDTH] = mid_mid_p0[ch*DATA_WIDTH +: DATA_WIDTH];
            win_next[(ch*9+4)*DATA_WIDTH +: DATA_WIDTH] = mid_rgt_p0[ch*DATA_WIDTH +: DATA_WIDTH];
            win_next[(ch*9+5)*DATA_WIDTH +: DATA_WIDTH] = a_rd[ch*DATA_WIDTH +: DATA_WIDTH];
            win_next[(ch*9+6)*DATA_WIDTH +: DATA_WIDTH] = bot_mid_p0[ch*DATA_WIDTH +: DATA_WIDTH];
            win_next[(ch*9+7)*DATA_WIDTH +: DATA_WIDTH] = bot_rgt_p0[ch*DATA_WIDTH +: DATA_WIDTH];
            win_next[(ch*9+8)*DATA_WIDTH +: DATA_WIDTH] = data_in[ch*DATA_WIDTH +: DATA_WIDTH];
        end
    end

    // Stage p0: line buffers and tap columns. Not reset: rows 0 and 1 of every
    // frame rewrite both buffers, and columns 0 and 1 of every row flush the
    // taps, before any window can be emitted.
    always_ff @(posedge Clk) begin
        if (accept) begin
            line_b[col] <= a_rd;
            line_a[col] <= data_in;
            top_mid_p0  <= top_rgt_p0;
            mid_mid_p0  <= mid_rgt_p0;
            bot_mid_p0  <= bot_rgt_p0;
            top_rgt_p0  <= b_rd;
            mid_rgt_p0  <= a_rd;
            bot_rgt_p0  <= data_in;
        end
    end

    // Stage p1: raster counters and registered window outputs.
    always_ff @(posedge Clk) begin
        if (Rst) begin
            col        <= '0;
            row        <= '0;
            vld_p1     <= 1'b0;
            last_out   <= 1'b0;
            window_out <= '0;
        end else begin
            vld_p1   <= emit;
            last_out <= emit_last;
            if (emit) begin
                window_out <= win_next;
            end
            if (accept) begin
                if (col == MAX_IDX) begin
                    col <= '0;
                    row <= (row == MAX_IDX) ? '0 : row + CNT_W'(1);
                end else begin
                    col <= col + CNT_W'(1);
                end
            end
        end
    end

    assign valid_out = vld_p1;

endmodule

// File: tb/tb_featuremap_window_gen.sv
// Bench for featuremap_window_gen: one stride-1 and one stride-2 instance
// share the same stimulus. A frame-image model predicts every output each cycle;
// directed scenarios add literal expectations on the captured windows.
module tb_featuremap_window_gen;

    localparam int DW = 16;
    localparam int CH = 2;
    localparam int N  = 5;
    localparam int PW = CH * DW;
    localparam int WW = 9 * PW;

    logic          Clk = 1'b0;
    logic          Rst;
    logic [PW-1:0] data_in;
    logic          valid_in;
    logic [WW-1:0] win1, win2;
    logic          vo1, vo2, lo1, lo2;

    int total = 0;
    int bad   = 0;

    always #5 Clk = ~Clk;

    featuremap_window_gen #(.DATA_WIDTH(DW), .CHANNELS(CH), .IMG_SIZE(N), .STRIDE(1)) dut1 (
        .Clk(Clk), .Rst(Rst), .data_in(data_in), .valid_in(valid_in),
        .window_out(win1), .valid_out(vo1), .last_out(lo1));

    featuremap_window_gen #(.DATA_WIDTH(DW), .CHANNELS(CH), .IMG_SIZE(N), .STRIDE(2)) dut2 (
        .Clk(Clk), .Rst(Rst), .data_in(data_in), .valid_in(valid_in),
        .window_out(win2), .valid_out(vo2), .last_out(lo2));

    task automatic chk(input string name, input logic [WW-1:0] act, input logic [WW-1:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    function automatic logic [DW-1:0] tap(input logic [WW-1:0] w, input int ch, input int k);
        return w[(ch*9+k)*DW +: DW];
    endfunction

    function automatic int last_idx(input int s);
        for (int k = N - 1; k >= 2; k--)
            if (((k - 2) % s) == 0) return k;
        return -1;
    endfunction

    // ---------------- behavioural model ----------------
    logic [DW-1:0] img [N][N][CH];
    int            mr, mc;
    logic          started = 1'b0;
    logic          exp_v [2];
    logic          exp_l [2];
    logic [WW-1:0] exp_w [2];

    always @(posedge Clk) begin
        started = 1'b1;
        if (Rst) begin
            mr = 0; mc = 0;
            for (int s = 0; s < 2; s++) begin
                exp_v[s] = 1'b0; exp_l[s] = 1'b0; exp_w[s] = '0;
            end
        end else if (valid_in) begin
            for (int ch = 0; ch < CH; ch++) img[mr][mc][ch] = data_in[ch*DW +: DW];
            for (int s = 0; s < 2; s++) begin
                int st;
                st = s + 1;
                if (mr >= 2 && mc >= 2 && ((mr - 2) % st) == 0 && ((mc - 2) % st) == 0) begin
                    exp_v[s] = 1'b1;
                    exp_l[s] = (mr == last_idx(st)) && (mc == last_idx(st));
                    for (int ch = 0; ch < CH; ch++)
                        for (int k = 0; k < 9; k++)
                            exp_w[s][(ch*9+k)*DW +: DW] = img[mr-2+k/3][mc-2+k%3][ch];
                end else begin
                    exp_v[s] = 1'b0;
                    exp_l[s] = 1'b0;
                end
            end
            if (mc == N - 1) begin
                mc = 0;
                mr = (mr == N - 1) ? 0 : mr + 1;
            end else begin
                mc = mc + 1;
            end
        end else begin
            for (int s = 0; s < 2; s++) begin
                exp_v[s] = 1'b0; exp_l[s] = 1'b0;
            end
        end
    end

    // ---------------- per-cycle compare + capture ----------------
    logic [WW-1:0] q1[$], q2[$];
    logic          ql1[$], ql2[$];

    always @(negedge Clk) begin
        if (started) begin
            chk("valid_s1", WW'(vo1), WW'(exp_v[0]));
            chk("last_s1",  WW'(lo1), WW'(exp_l[0]));
            chk("win_s1",   win1,     exp_w[0]);
            chk("valid_s2", WW'(vo2), WW'(exp_v[1]));
            chk("last_s2",  WW'(lo2), WW'(exp_l[1]));
            chk("win_s2",   win2,     exp_w[1]);
            if (vo1) begin q1.push_back(win1); ql1.push_back(lo1); end
            if (vo2) begin q2.push_back(win2); ql2.push_back(lo2); end
        end
    end

    // ---------------- stimulus ----------------
    task automatic tick(input logic v, input logic r, input logic [PW-1:0] d);
        valid_in = v; Rst = r; data_in = d;
        @(negedge Clk);
    endtask

    function automatic logic [PW-1:0] pix(input int off, input int r, input int c);
        logic [PW-1:0] d;
        for (int ch = 0; ch < CH; ch++) d[ch*DW +: DW] = DW'(ch*1000 + r*10 + c + off);
        return d;
    endfunction

    task automatic frame(input int off, input bit gap, input int stop_at);
        for (int i = 0; i < N*N; i++) begin
            if (i == stop_at) return;
            tick(1'b1, 1'b0, pix(off, i / N, i % N));
            if (gap) tick(1'b0, 1'b0, PW'($urandom));
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick(1'b0, 1'b0, '0);
    endtask

    task automatic clear_q();
        q1.delete(); q2.delete(); ql1.delete(); ql2.delete();
    endtask

    function automatic int count_last(input logic q[$]);
        int n = 0;
        foreach (q[i]) if (q[i]) n++;
        return n;
    endfunction

    initial begin
        logic [WW-1:0] ref1 [$];
        int            exp0 [9];
        int            w8s2 [4];
        int            viol;
        exp0 = '{0, 1, 2, 10, 11, 12, 20, 21, 22};
        w8s2 = '{22, 24, 42, 44};
        Rst = 1'b1; valid_in = 1'b0; data_in = '0;
        @(negedge Clk);
        tick(1'b0, 1'b1, '0);

        // reset state
        chk("rst_valid", WW'(vo1), '0);
        chk("rst_last",  WW'(lo1), '0);
        chk("rst_win",   win1,     '0);

        // continuous frame: stride 1 and stride 2
        clear_q();
        frame(0, 1'b0, N*N);
        idle(2);
        chk("s1_count", WW'(q1.size()), WW'(9));
        if (q1.size() == 9) begin
            for (int k = 0; k < 9; k++) chk("s1_first_ch0", WW'(tap(q1[0], 0, k)), WW'(exp0[k]));
            chk("s1_first_ch1_w8", WW'(tap(q1[0], 1, 8)), WW'(1022));
            chk("s1_last_w8", WW'(tap(q1[8], 0, 8)), WW'(44));
            chk("s1_last_flag", WW'(ql1[8]), WW'(1));
        end
        chk("s1_last_count", WW'(count_last(ql1)), WW'(1));
        chk("s2_count", WW'(q2.size()), WW'(4));
        if (q2.size() == 4)
            for (int i = 0; i < 4; i++) chk("s2_w8", WW'(tap(q2[i], 0, 8)), WW'(w8s2[i]));
        chk("s2_last_count", WW'(count_last(ql2)), WW'(1));
        if (ql2.size() == 4) chk("s2_last_pos", WW'(ql2[3]), WW'(1));
        ref1 = q1;

        // valid_in toggling every cycle
        clear_q();
        frame(0, 1'b1, N*N);
        idle(2);
        chk("gap_count", WW'(q1.size()), WW'(9));
        if (q1.size() == 9 && ref1.size() == 9)
            for (int i = 0; i < 9; i++) chk("gap_same", q1[i], ref1[i]);

        // back-to-back frames
        clear_q();
        frame(0, 1'b0, N*N);
        frame(100, 1'b0, N*N);
        idle(2);
        chk("b2b_count", WW'(q1.size()), WW'(18));
        chk("b2b_lasts", WW'(count_last(ql1)), WW'(2));
        if (q1.size() == 18) begin
            chk("b2b_f2_w0", WW'(tap(q1[9], 0, 0)), WW'(100));
            chk("b2b_f2_w8", WW'(tap(q1[9], 0, 8)), WW'(122));
            viol = 0;
            for (int i = 9; i < 18; i++)
                for (int k = 0; k < 9; k++)
                    if (tap(q1[i], 0, k) < 100) viol++;
            chk("b2b_no_stale", WW'(viol), '0);
        end

        // reset mid-frame after pixel (3,1)
        frame(0, 1'b0, 3*N + 2);
        idle(1);
        clear_q();
        tick(1'b0, 1'b1, '0);
        chk("midrst_valid", WW'(vo1), '0);
        frame(0, 1'b0, N*N);
        idle(2);
        chk("midrst_count", WW'(q1.size()), WW'(9));
        chk("midrst_lasts", WW'(count_last(ql1)), WW'(1));

        // reset together with valid_in right as a window is on the outputs
        frame(0, 1'b0, 2*N + 3);
        tick(1'b1, 1'b1, pix(0, 9, 9));
        chk("rstv_valid", WW'(vo1), '0);
        chk("rstv_last",  WW'(lo1), '0);
        chk("rstv_win",   win1,     '0);
        clear_q();
        frame(0, 1'b0, N*N);
        idle(2);
        chk("rstv_count", WW'(q1.size()), WW'(9));
        if (q1.size() == 9)
            for (int k = 0; k < 9; k++) chk("rstv_first", WW'(tap(q1[0], 0, k)), WW'(exp0[k]));

        // randomized traffic with occasional resets
        for (int i = 0; i < 600; i++)
            tick(($urandom % 4) != 0, ($urandom % 150) == 0, PW'($urandom));
        idle(2);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
